// File: rtl/nonce_decoder_if.sv
// Result bundle reported by the hashing cores each round.
interface processorResultsIfc #(
    parameter int PARTITIONBITS = 4
);
    logic                     success;
    logic [PARTITIONBITS-1:0] nonce_prefix;

    modport reader (input success, input nonce_prefix);
    modport writer (output success, output nonce_prefix);
endinterface

// File: rtl/nonce_decoder.sv
// Turns per-round core results into full nonces once the broadcast/warm-up
// phase of a block is over; outputs are registered with one cycle of latency.
module nonce_decoder #(
    parameter int BROADCAST_CNT = 5,
    parameter int NUM_CORES     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic                     newblock_i,
    processorResultsIfc.reader       rawinput_i,
    output logic                     valid_o,
    output logic                     success_o,
    output logic [31:0]              nonce_o
);

    localparam logic [31:0] BCNT_LAST = 32'(BROADCAST_CNT);
    localparam logic [31:0] CORES     = 32'(NUM_CORES);

    typedef enum logic [1:0] {
        IDLE,
        BROADCAST,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] iter_q, iter_d;
    logic [31:0] bcnt_q, bcnt_d;
    logic        valid_q, valid_d;
    logic        success_q, success_d;
    logic [31:0] nonce_q, nonce_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            bcnt_q    <= '0;
            valid_q   <= 1'b0;
            success_q <= 1'b0;
            nonce_q   <= '0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            bcnt_q    <= bcnt_d;
            valid_q   <= valid_d;
            success_q <= success_d;
            nonce_q   <= nonce_d;
        end
    end

    // The newblock cycle itself is the first of the BROADCAST_CNT consumed cycles.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        bcnt_d  = bcnt_q;
        if (valid_i) begin
            if (newblock_i) begin
                iter_d  = '0;
                bcnt_d  = 32'd1;
                state_d = (BCNT_LAST == 32'd1) ? RUN : BROADCAST;
            end else begin
                case (state_q)
                    BROADCAST: begin
                        bcnt_d = bcnt_q + 32'd1;
                        if (bcnt_q + 32'd1 == BCNT_LAST) state_d = RUN;
                    end
                    RUN:     iter_d = iter_q + 32'd1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        valid_d   = 1'b0;
        success_d = 1'b0;
        nonce_d   = nonce_q;
        if (valid_i && !newblock_i && state_q == RUN) begin
            valid_d   = 1'b1;
            success_d = rawinput_i.success;
            nonce_d   = iter_q * CORES + 32'(rawinput_i.nonce_prefix);
        end
    end

    assign valid_o   = valid_q;
    assign success_o = success_q;
    assign nonce_o   = nonce_q;

endmodule

// File: tb/tb_nonce_decoder.sv
// Bench for nonce_decoder: directed vector table, scenario sequences, a
// modulo-wrap instance and randomized traffic against a count-based model.
module tb_nonce_decoder;

    localparam int BC = 5;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        newblock_i = 1'b0;
    logic        valid_o, success_o;
    logic [31:0] nonce_o;
    logic        valid2_o, success2_o;
    logic [31:0] nonce2_o;

    int n_checks = 0;
    int n_fail   = 0;

    processorResultsIfc #(.PARTITIONBITS(4)) ifc  ();
    processorResultsIfc #(.PARTITIONBITS(4)) ifc2 ();

    nonce_decoder #(.BROADCAST_CNT(BC), .NUM_CORES(NC)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .newblock_i(newblock_i),
        .rawinput_i(ifc.reader),
        .valid_o(valid_o), .success_o(success_o), .nonce_o(nonce_o)
    );

    // Huge core count so that the modulo-2^32 wrap is reached in a few cycles.
    nonce_decoder #(.BROADCAST_CNT(1), .NUM_CORES(32'h4000_0000)) dut2 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .newblock_i(newblock_i),
        .rawinput_i(ifc2.reader),
        .valid_o(valid2_o), .success_o(success2_o), .nonce_o(nonce2_o)
    );

    always #5 clk = ~clk;

    // Reference model: counts valid cycles since the last accepted newblock.
    logic    m_active = 1'b0;
    longint  m_seen   = 0;
    logic    m_valid  = 1'b0;
    logic    m_succ   = 1'b0;
    logic [31:0] m_nonce = '0;

    task automatic model_update(input logic r, v, nb, s, input logic [3:0] p);
        longint idx;
        if (r) begin
            m_active = 1'b0; m_seen = 0;
            m_valid = 1'b0; m_succ = 1'b0; m_nonce = '0;
        end else if (!v) begin
            m_valid = 1'b0; m_succ = 1'b0;
        end else if (nb) begin
            m_active = 1'b1; m_seen = 1;
            m_valid = 1'b0; m_succ = 1'b0;
        end else if (m_active) begin
            m_seen++;
            if (m_seen > BC) begin
                idx     = m_seen - BC - 1;
                m_valid = 1'b1;
                m_succ  = s;
                m_nonce = 32'((idx * NC + longint'(p)) % 64'h1_0000_0000);
            end else begin
                m_valid = 1'b0; m_succ = 1'b0;
            end
        end else begin
            m_valid = 1'b0; m_succ = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, v, nb, s, input logic [3:0] p);
        @(negedge clk);
        rst = r; valid_i = v; newblock_i = nb;
        ifc.success = s; ifc.nonce_prefix = p;
        ifc2.success = s;
        @(posedge clk);
        #1;
        model_update(r, v, nb, s, p);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(valid_o), 32'(m_valid));
        check({tag, "_success"}, 32'(success_o), 32'(m_succ));
        check({tag, "_nonce"}, nonce_o, m_nonce);
    endtask

    typedef struct {
        logic        r, v, nb, s;
        logic [3:0]  p;
        logic        ev, es;
        logic [31:0] en;
    } vec_t;

    vec_t vecs[23];

    initial begin
        ifc.success = 1'b0; ifc.nonce_prefix = 4'd5;
        ifc2.success = 1'b0; ifc2.nonce_prefix = 4'd3;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 32'd5};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 32'd9};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 32'd13};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 32'd13};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 32'd13};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 32'd27};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 32'd27};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd27};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd27};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd27};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 32'd27};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 32'd5};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 32'd9};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 32'd0};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 32'd0};

        // Directed table: broadcast, run, hit, gaps, ignored newblock, restart, reset.
        for (int unsigned i = 0; i < 23; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].nb, vecs[i].s, vecs[i].p);
            check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].ev));
            check($sformatf("vec%0d_success", i), 32'(success_o), 32'(vecs[i].es));
            check($sformatf("vec%0d_nonce", i), nonce_o, vecs[i].en);
        end

        // Newblock followed by 15 valid cycles: 5 silent, then 5, 9, ..., 41.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        for (int unsigned i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, (i == 0), 1'b0, 4'd5);
            check("seq15_valid", 32'(valid_o), (i < 5) ? 32'd0 : 32'd1);
            check("seq15_success", 32'(success_o), 32'd0);
            if (i >= 5) check("seq15_nonce", nonce_o, 32'(5 + 4 * (i - 5)));
        end

        // Reset mid-RUN together with valid, then valid without newblock stays silent.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        check("rst_mid_run_valid", 32'(valid_o), 32'd0);
        check("rst_mid_run_nonce", nonce_o, 32'd0);
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
            check("after_rst_valid", 32'(valid_o), 32'd0);
            check("after_rst_success", 32'(success_o), 32'd0);
        end

        // Modulo-2^32 wrap on the large-core instance (BROADCAST_CNT=1, prefix 3).
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("wrap_nb_valid", 32'(valid2_o), 32'd0);
        for (int unsigned i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            check("wrap_valid", 32'(valid2_o), 32'd1);
            check("wrap_nonce", nonce2_o, 32'((longint'(i) * 64'h4000_0000 + 3) % 64'h1_0000_0000));
        end

        // Randomized traffic against the model.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check_model("rand_rst");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check_model("rand_nb");
        for (int unsigned i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
            check_model("rand");
            if (success_o && !valid_o) check("success_without_valid", 32'd1, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nonce_decoder.md
NONCE_DECODER -- requirements
Module: nonce_decoder

Interface
REQ-001 Parameter BROADCAST_CNT, default 5: number of valid cycles a new block spends in broadcast/warm-up before results are decoded; legal range 1 or more.
REQ-002 Parameter NUM_CORES, default 4: number of hashing cores, each owning one nonce partition; legal range 1 or more.
REQ-003 Interface parameter PARTITIONBITS, default 4: width of nonce_prefix in processorResultsIfc; it is taken from the connected interface.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 valid_i  input  1  a core result round is present this cycle.
REQ-007 newblock_i  input  1  first cycle of a new block; qualified by valid_i.
REQ-008 rawinput_i  processorResultsIfc.reader  carries success (1 bit, some core found a hit this round) and nonce_prefix (PARTITIONBITS bits, index of the reporting core).
REQ-009 valid_o  output  1  decoded result present.
REQ-010 success_o  output  1  decoded round was a hit.
REQ-011 nonce_o  output  32  decoded full nonce.

Function
REQ-012 The block SHALL have three states: IDLE, BROADCAST and RUN, plus a 32-bit iteration counter iter and a broadcast counter bcnt.
REQ-013 A valid_i=1 and newblock_i=1 cycle, from any state, SHALL move the block to BROADCAST with bcnt=1 and iter=0; if BROADCAST_CNT=1, it SHALL move to RUN instead.
REQ-014 newblock_i=1 with valid_i=0 SHALL be ignored.
REQ-015 In BROADCAST, each valid_i=1 cycle without newblock_i SHALL increment bcnt, and the block SHALL enter RUN when bcnt reaches BROADCAST_CNT, so the first BROADCAST_CNT valid cycles of a block are consumed.
REQ-016 In BROADCAST, valid_o SHALL be 0.
REQ-017 In RUN, each valid_i=1 cycle without newblock_i SHALL register outputs at the next edge: valid_o=1, success_o=rawinput_i.success, nonce_o=(iter*NUM_CORES + nonce_prefix) mod 2^32; iter SHALL then increment.
REQ-018 The latency from a RUN-state input to its output SHALL be exactly 1 clock; the outputs SHALL be registered.
REQ-019 Any cycle with valid_i=0 SHALL yield valid_o=0 and success_o=0 at the next edge; nonce_o, iter, bcnt and the state SHALL hold.
REQ-020 In IDLE, valid_i without newblock_i SHALL be ignored: no output and no state change.
REQ-021 iter SHALL wrap from 2^32-1 to 0; the nonce arithmetic SHALL be modulo 2^32.
REQ-022 nonce_prefix SHALL be used unmodified, zero-extended, even if its value is at least NUM_CORES.
REQ-023 success_o SHALL never be 1 while valid_o is 0.
REQ-024 A hit SHALL NOT stop decoding; RUN continues until the next newblock_i or reset.
REQ-025 A newblock_i during RUN SHALL restart the sequence per REQ-013 and produce no output for that cycle.

Reset
REQ-026 On rst=1 at a rising edge, the block SHALL enter IDLE with iter=0, bcnt=0, valid_o=0, success_o=0 and nonce_o=0.
REQ-027 rst SHALL override all other inputs, including simultaneous valid_i and newblock_i.
REQ-028 A reset mid-BROADCAST or mid-RUN SHALL abort the block; a fresh newblock_i is then required.

Verification
REQ-029 Scenario: BROADCAST_CNT=5, NUM_CORES=4, prefix=5, success=0; reset, then newblock with valid held for 15 cycles -> valid_o is 0 for the first 5 valid cycles, then 1 for 10 cycles with nonce_o 5, 9, 13, ..., 41 and success_o 0.
REQ-030 Scenario: same setup, success=1 on the 3rd RUN cycle -> success_o=1 with nonce_o=13 only on that output cycle.
REQ-031 Scenario: valid_i dropped for 2 cycles mid-RUN -> valid_o=0 for 2 cycles, nonce_o held, and the next result continues with iter+1 and no skip.
REQ-032 Scenario: newblock_i while in RUN -> 5 silent valid cycles follow, then nonce_o restarts at prefix (5).
REQ-033 Scenario: rst asserted mid-RUN together with valid_i -> all outputs 0 next cycle; later valid_i without newblock_i gives no outputs.
REQ-034 Scenario: iter preloaded near wrap, NUM_CORES=4, prefix=3 -> nonce_o wraps modulo 2^32 without error.
